// File: rtl/seq_add_sub_pkg.sv
// seq_add_sub_pkg: shared state type, index-width helper and parameter legality check.
package seq_add_sub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Never returns less than 1, so a single-chunk build still gets a usable index register.
    function automatic int clog2(input int v);
        int r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic bit params_ok(input int width, input int chunk);
        return width >= 2 && chunk >= 1 && chunk <= width && width % chunk == 0;
    endfunction
endpackage

// File: rtl/seq_add_sub_if.sv
// seq_add_sub_if: operand and result valid/ready handshakes for the sequential adder/subtractor.
interface seq_add_sub_if #(parameter int WIDTH = 16);
    logic in_valid, in_ready, sub, cin;
    logic [WIDTH-1:0] a, b, sum;
    logic out_valid, out_ready, cout, ovf, zero, neg;
    modport master (
        output in_valid, a, b, sub, cin, out_ready,
        input in_ready, out_valid, sum, cout, ovf, zero, neg
    );
    modport slave (
        input in_valid, a, b, sub, cin, out_ready,
        output in_ready, out_valid, sum, cout, ovf, zero, neg
    );
endinterface

// File: rtl/seq_add_sub_ripple_chunk_adder.sv
// ripple_chunk_adder: combinational CHUNK-bit full-adder chain shared across all chunks.
module ripple_chunk_adder #(parameter int CHUNK = 4) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb_in
);
    logic c;
    always_comb begin
        s = '0;
        c = ci;
        c_msb_in = ci;
        for (int i = 0; i < CHUNK; i++) begin
            c_msb_in = c;
            s[i] = a[i] ^ b[i] ^ c;
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end
endmodule

// File: rtl/seq_add_sub.sv
// seq_add_sub: WIDTH-bit add/subtract computed CHUNK bits per cycle through one shared ripple slice.
module seq_add_sub
    import seq_add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input logic clk,
    input logic rst_n,
    seq_add_sub_if.slave bus
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = clog2(NCHUNK);

    if (!params_ok(WIDTH, CHUNK)) begin : g_bad_params
        $fatal(1, "seq_add_sub: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    state_t state;
    logic [WIDTH-1:0] opa, opb, work, work_nx, sum;
    logic [IW-1:0] idx;
    logic [CHUNK-1:0] s;
    logic carry, co, c_msb, cout, ovf, zero, neg, last;

    ripple_chunk_adder #(.CHUNK(CHUNK)) u_slice (
        .a(opa[CHUNK-1:0]), .b(opb[CHUNK-1:0]), .ci(carry),
        .s(s), .co(co), .c_msb_in(c_msb)
    );

    // Each new chunk lands at the top, so after NCHUNK steps the first chunk sits at bit 0.
    assign work_nx = (work >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));
    assign last = idx == IW'(NCHUNK - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            opa <= '0;
            opb <= '0;
            carry <= 1'b0;
            idx <= '0;
            work <= '0;
            sum <= '0;
            cout <= 1'b0;
            ovf <= 1'b0;
            zero <= 1'b0;
            neg <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    state <= RUN;
                    opa <= bus.a;
                    opb <= bus.sub ? ~bus.b : bus.b;
                    carry <= bus.sub ^ bus.cin;
                    idx <= '0;
                    work <= '0;
                end
                RUN: begin
                    opa <= opa >> CHUNK;
                    opb <= opb >> CHUNK;
                    carry <= co;
                    idx <= idx + 1'b1;
                    work <= work_nx;
                    if (last) begin
                        state <= DONE;
                        sum <= work_nx;
                        cout <= co;
                        ovf <= co ^ c_msb;
                        zero <= work_nx == '0;
                        neg <= work_nx[WIDTH-1];
                    end
                end
                DONE: state <= bus.out_ready ? IDLE : DONE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.sum = sum;
    assign bus.cout = cout;
    assign bus.ovf = ovf;
    assign bus.zero = zero;
    assign bus.neg = neg;
endmodule

// File: tb/tb_seq_add_sub.sv
// tb_seq_add_sub: table-driven and scoreboarded checks of seq_add_sub at WIDTH=16, CHUNK=4.
module tb_seq_add_sub;
    localparam int W = 16;
    localparam int NCH = 4;

    typedef struct {
        logic [W-1:0] a, b;
        logic sub, cin;
        logic [W-1:0] s;
        logic co, ov, z, n;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int total = 0;
    int bad = 0;
    vec_t sb[$];
    vec_t vecs[8];

    seq_add_sub_if #(.WIDTH(W)) bus ();
    seq_add_sub #(.WIDTH(W), .CHUNK(NCH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    function automatic vec_t vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                 input logic cin, input logic [W-1:0] s, input logic co,
                                 input logic ov, input logic z, input logic n);
        vec_t v;
        v.a = a; v.b = b; v.sub = sub; v.cin = cin;
        v.s = s; v.co = co; v.ov = ov; v.z = z; v.n = n;
        return v;
    endfunction

    // Reference arithmetic on a W+1-bit accumulator with sign-rule overflow detection.
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                                   input logic cin);
        vec_t v;
        logic [W:0] f;
        v.a = a; v.b = b; v.sub = sub; v.cin = cin;
        if (sub) f = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~cin};
        else f = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        v.s = f[W-1:0];
        v.co = f[W];
        v.ov = sub ? (a[W-1] != b[W-1]) && (v.s[W-1] != a[W-1])
                   : (a[W-1] == b[W-1]) && (v.s[W-1] != a[W-1]);
        v.z = v.s == '0;
        v.n = v.s[W-1];
        return v;
    endfunction

    // Called and returning at a negedge; hold > 0 stalls out_ready while a rival request is offered.
    task automatic run_op(input vec_t v, input int hold);
        int k;
        vec_t e;
        k = 0;
        while (!bus.in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check1("accept_ready", bus.in_ready, 1'b1);
        bus.a = v.a; bus.b = v.b; bus.sub = v.sub; bus.cin = v.cin; bus.in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(v);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = ~v.a;
        bus.b = ~v.b;
        bus.sub = ~v.sub;
        k = 0;
        while (!bus.out_valid && k < 20) begin
            k++;
            @(negedge clk);
        end
        check1("out_valid", bus.out_valid, 1'b1);
        check("latency", W'(k), W'(NCH));
        e = sb.pop_front();
        if (hold > 0) begin
            bus.in_valid = 1'b1;
            bus.a = 16'hAAAA;
            repeat (hold) begin
                @(negedge clk);
                check("hold_sum", bus.sum, e.s);
                check1("hold_valid", bus.out_valid, 1'b1);
                check1("hold_in_ready", bus.in_ready, 1'b0);
            end
            bus.in_valid = 1'b0;
        end
        check("sum", bus.sum, e.s);
        check1("cout", bus.cout, e.co);
        check1("ovf", bus.ovf, e.ov);
        check1("zero", bus.zero, e.z);
        check1("neg", bus.neg, e.n);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check1("idle_in_ready", bus.in_ready, 1'b1);
        check1("idle_out_valid", bus.out_valid, 1'b0);
        check("idle_sum_held", bus.sum, e.s);
    endtask

    initial begin
        logic seen;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.cin = 1'b0;
        vecs[0] = vec(16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0, 1'b0, 1'b0);
        vecs[1] = vec(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[2] = vec(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
        vecs[3] = vec(16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
        vecs[4] = vec(16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[5] = vec(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFD, 1'b0, 1'b0, 1'b0, 1'b1);
        vecs[6] = vec(16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
        vecs[7] = vec(16'h00FF, 16'h0F00, 1'b0, 1'b1, 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);

        #12;
        check1("rst_in_ready", bus.in_ready, 1'b1);
        check1("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_sum", bus.sum, 16'h0000);
        check1("rst_cout", bus.cout, 1'b0);
        check1("rst_ovf", bus.ovf, 1'b0);
        check1("rst_zero", bus.zero, 1'b0);
        check1("rst_neg", bus.neg, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) run_op(vecs[i], 0);

        run_op(vec(16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0, 1'b0, 1'b0, 1'b0), 6);
        run_op(vec(16'hAAAA, 16'h1111, 1'b0, 1'b0, 16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b1), 0);

        for (int i = 0; i < 6; i++)
            run_op(model(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom)), 0);

        bus.a = 16'h0300; bus.b = 16'h0400; bus.sub = 1'b0; bus.cin = 1'b0; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check1("midrun_rst_in_ready", bus.in_ready, 1'b1);
        check1("midrun_rst_out_valid", bus.out_valid, 1'b0);
        check("midrun_rst_sum", bus.sum, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen |= bus.out_valid;
        end
        check1("no_ghost_valid", seen, 1'b0);
        run_op(vec(16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
